// File: rtl/rename_free_list_pkg.sv
// Shared types and sizing for the rename free-list controller and its FIFO.
package rename_free_list_pkg;

    localparam int unsigned REG_W     = 6;
    localparam int unsigned ARCH_REGS = 32;
    localparam int unsigned PHYS_REGS = 64;
    localparam int unsigned POOL      = PHYS_REGS - ARCH_REGS;
    localparam int unsigned PTR_W     = $clog2(POOL);
    localparam int unsigned CNT_W     = $clog2(POOL + 1);

    typedef logic [REG_W-1:0] phys_reg_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef logic [1:0] rename_state_e;
    localparam rename_state_e RUN     = 2'd0;
    localparam rename_state_e SPEC    = 2'd1;
    localparam rename_state_e RECOVER = 2'd2;

    typedef struct packed {
        ptr_t head;
        cnt_t spec_alloc;
    } rename_ckpt_t;

    // Advance a FIFO pointer by 0..2 entries, wrapping modulo POOL.
    function automatic ptr_t ptr_add(input ptr_t p, input logic [1:0] n);
        logic [PTR_W:0] s;
        s = {1'b0, p} + {{(PTR_W-1){1'b0}}, n};
        if (s >= (PTR_W+1)'(POOL)) s = s - (PTR_W+1)'(POOL);
        return s[PTR_W-1:0];
    endfunction

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/rename_free_list_ctrl_fifo.sv
// Circular buffer of free rename ids: two reads at head, two pushes at tail, head reload for rollback.
module rename_free_fifo
    import rename_free_list_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            pop_cnt,
    input  logic [1:0]            free_valid,
    input  logic [1:0][REG_W-1:0] free_reg,
    input  logic                  load_head,
    input  logic [PTR_W-1:0]      load_val,
    input  logic [CNT_W-1:0]      restore_cnt,
    output logic [1:0][REG_W-1:0] rd_reg,
    output logic [PTR_W-1:0]      head,
    output logic [CNT_W-1:0]      count,
    output logic                  drop_c
);

    phys_reg_t mem_q [POOL];
    phys_reg_t mem_d [POOL];
    ptr_t      head_q, head_d;
    ptr_t      tail_q, tail_d;
    cnt_t      count_q, count_d;
    logic      acc0, acc1;
    cnt_t      cnt_after0;

    // Push acceptance: architectural ids and pushes into a full pool are dropped.
    always_comb begin
        mem_d      = mem_q;
        tail_d     = tail_q;
        acc0       = free_valid[0] && (free_reg[0] >= REG_W'(ARCH_REGS)) && (count_q != CNT_W'(POOL));
        cnt_after0 = count_q + CNT_W'(acc0);
        acc1       = free_valid[1] && (free_reg[1] >= REG_W'(ARCH_REGS)) && (cnt_after0 != CNT_W'(POOL));
        if (acc0) begin
            mem_d[tail_d] = free_reg[0];
            tail_d        = ptr_add(tail_d, 2'd1);
        end
        if (acc1) begin
            mem_d[tail_d] = free_reg[1];
            tail_d        = ptr_add(tail_d, 2'd1);
        end
        head_d  = load_head ? load_val : ptr_add(head_q, pop_cnt);
        count_d = count_q - CNT_W'(pop_cnt) + CNT_W'(acc0) + CNT_W'(acc1)
                + (load_head ? restore_cnt : CNT_W'(0));
        drop_c  = (free_valid[0] && !acc0) || (free_valid[1] && !acc1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(POOL); k++) mem_q[k] <= REG_W'(ARCH_REGS + k);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(POOL);
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign rd_reg[0] = mem_q[head_q];
    assign rd_reg[1] = mem_q[ptr_add(head_q, 2'd1)];
    assign head      = head_q;
    assign count     = count_q;

endmodule

// File: rtl/rename_free_list_ctrl.sv
// Rename register free-list controller: grants, one-deep speculation checkpoint, error flag.
// Optional statistics counters when RENAME_STATS_EN is defined.
module rename_free_list_ctrl
    import rename_free_list_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            alloc_req,
    output logic [1:0]            alloc_gnt,
    output logic [1:0][REG_W-1:0] alloc_reg,
    output logic                  stall,
    input  logic [1:0]            free_valid,
    input  logic [1:0][REG_W-1:0] free_reg,
    input  logic                  spec_begin,
    input  logic                  spec_slot,
    input  logic                  spec_commit,
    input  logic                  spec_clear,
    output logic                  spec_busy,
    output logic [CNT_W-1:0]      free_count,
`ifdef RENAME_STATS_EN
    output logic [31:0]           stat_stall_cycles,
    output logic [31:0]           stat_allocs,
    output logic [15:0]           stat_rollbacks,
`endif
    output logic                  error
);

    rename_state_e         state_q, state_d;
    rename_ckpt_t          ckpt_q, ckpt_d;
    logic                  error_q, error_d;
    logic [1:0][REG_W-1:0] rd_reg;
    ptr_t                  head;
    cnt_t                  count;
    logic                  drop_c;
    logic                  load_head;
    logic [1:0]            n_req, n_gnt, pre_cnt, post_cnt;
    logic                  grant_ok;

    rename_free_fifo u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .pop_cnt     (n_gnt),
        .free_valid  (free_valid),
        .free_reg    (free_reg),
        .load_head   (load_head),
        .load_val    (ckpt_q.head),
        .restore_cnt (ckpt_q.spec_alloc),
        .rd_reg      (rd_reg),
        .head        (head),
        .count       (count),
        .drop_c      (drop_c)
    );

    // All-or-nothing grant; the lowest requesting slot takes the head entry.
    always_comb begin
        n_req     = popcount2(alloc_req);
        grant_ok  = (state_q != RECOVER) && !spec_clear && (count >= CNT_W'(n_req));
        alloc_gnt = grant_ok ? alloc_req : 2'b00;
        n_gnt     = popcount2(alloc_gnt);
        alloc_reg = '0;
        if (alloc_gnt[0]) alloc_reg[0] = rd_reg[0];
        if (alloc_gnt[1]) alloc_reg[1] = alloc_gnt[0] ? rd_reg[1] : rd_reg[0];
        stall     = (|alloc_req) && !(|alloc_gnt);
        pre_cnt   = spec_slot ? n_gnt : {1'b0, alloc_gnt[0]};
        post_cnt  = spec_slot ? 2'd0  : {1'b0, alloc_gnt[1]};
    end

    // Checkpoint FSM; rollback is a head reload plus a count restore inside the FIFO.
    always_comb begin
        state_d   = state_q;
        ckpt_d    = ckpt_q;
        error_d   = error_q | drop_c;
        load_head = 1'b0;
        case (state_q)
            RUN: begin
                if (spec_begin) begin
                    state_d           = SPEC;
                    ckpt_d.head       = ptr_add(head, pre_cnt);
                    ckpt_d.spec_alloc = CNT_W'(post_cnt);
                end
            end
            SPEC: begin
                if (spec_clear) begin
                    state_d   = RECOVER;
                    load_head = 1'b1;
                    if (spec_begin && !spec_commit) error_d = 1'b1;
                end else if (spec_commit) begin
                    if (spec_begin) begin
                        ckpt_d.head       = ptr_add(head, pre_cnt);
                        ckpt_d.spec_alloc = CNT_W'(post_cnt);
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    ckpt_d.spec_alloc = ckpt_q.spec_alloc + CNT_W'(n_gnt);
                    if (spec_begin) error_d = 1'b1;
                end
            end
            RECOVER: begin
                state_d = RUN;
                if (spec_begin) error_d = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            ckpt_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ckpt_q  <= ckpt_d;
            error_q <= error_d;
        end
    end

    assign spec_busy  = (state_q != RUN);
    assign free_count = count;
    assign error      = error_q;

`ifdef RENAME_STATS_EN
    logic [31:0] stall_cyc_q, stall_cyc_d;
    logic [31:0] allocs_q, allocs_d;
    logic [15:0] rollbacks_q, rollbacks_d;

    // Saturating event counters.
    always_comb begin
        stall_cyc_d = stall_cyc_q;
        allocs_d    = allocs_q;
        rollbacks_d = rollbacks_q;
        if (stall && (stall_cyc_q != 32'hFFFF_FFFF)) stall_cyc_d = stall_cyc_q + 32'd1;
        if (allocs_q > (32'hFFFF_FFFF - 32'(n_gnt))) allocs_d = 32'hFFFF_FFFF;
        else                                         allocs_d = allocs_q + 32'(n_gnt);
        if (load_head && (rollbacks_q != 16'hFFFF)) rollbacks_d = rollbacks_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cyc_q <= '0;
            allocs_q    <= '0;
            rollbacks_q <= '0;
        end else begin
            stall_cyc_q <= stall_cyc_d;
            allocs_q    <= allocs_d;
            rollbacks_q <= rollbacks_d;
        end
    end

    assign stat_stall_cycles = stall_cyc_q;
    assign stat_allocs       = allocs_q;
    assign stat_rollbacks    = rollbacks_q;
`endif

endmodule

// File: tb/tb_rename_free_list_ctrl.sv
// Directed bench for rename_free_list_ctrl with hand-computed expectations.
module tb_rename_free_list_ctrl;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       alloc_req;
    logic [1:0]       alloc_gnt;
    logic [1:0][5:0]  alloc_reg;
    logic             stall;
    logic [1:0]       free_valid;
    logic [1:0][5:0]  free_reg;
    logic             spec_begin, spec_slot, spec_commit, spec_clear;
    logic             spec_busy;
    logic [5:0]       free_count;
    logic             error;
`ifdef RENAME_STATS_EN
    logic [31:0]      stat_stall_cycles, stat_allocs;
    logic [15:0]      stat_rollbacks;
`endif

    int checks   = 0;
    int failures = 0;
    int q[$];
    int prev, exp_id;

    always #5 clk = ~clk;

    rename_free_list_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_req   (alloc_req),
        .alloc_gnt   (alloc_gnt),
        .alloc_reg   (alloc_reg),
        .stall       (stall),
        .free_valid  (free_valid),
        .free_reg    (free_reg),
        .spec_begin  (spec_begin),
        .spec_slot   (spec_slot),
        .spec_commit (spec_commit),
        .spec_clear  (spec_clear),
        .spec_busy   (spec_busy),
        .free_count  (free_count),
`ifdef RENAME_STATS_EN
        .stat_stall_cycles (stat_stall_cycles),
        .stat_allocs       (stat_allocs),
        .stat_rollbacks    (stat_rollbacks),
`endif
        .error       (error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        check("rst_cnt", 32'(free_count), 32);
        check("rst_busy", 32'(spec_busy), 0);
        check("rst_err", 32'(error), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; alloc_req = '0; free_valid = '0; free_reg = '0;
        spec_begin = 0; spec_slot = 0; spec_commit = 0; spec_clear = 0;
        #12;
        check("reset_count", 32'(free_count), 32);
        check("reset_busy", 32'(spec_busy), 0);
        check("reset_error", 32'(error), 0);
        check("reset_gnt", 32'(alloc_gnt), 0);
        check("reset_stall", 32'(stall), 0);
        rst_n = 1'b1;
        tick();

        // Basic dual allocation
        alloc_req = 2'b11; #1;
        check("t1_gnt", 32'(alloc_gnt), 3);
        check("t1_r0", 32'(alloc_reg[0]), 32);
        check("t1_r1", 32'(alloc_reg[1]), 33);
        tick();
        check("t1_cnt30", 32'(free_count), 30);
        #1;
        check("t1_r0b", 32'(alloc_reg[0]), 34);
        check("t1_r1b", 32'(alloc_reg[1]), 35);
        tick();
        check("t1_cnt28", 32'(free_count), 28);

        // Checkpoint after slot 0, then mispredict rollback
        spec_begin = 1; spec_slot = 0; #1;
        check("t3_r0", 32'(alloc_reg[0]), 36);
        check("t3_r1", 32'(alloc_reg[1]), 37);
        tick();
        spec_begin = 0;
        check("t3_busy", 32'(spec_busy), 1);
        check("t3_cnt26", 32'(free_count), 26);
        #1;
        check("t3_r0b", 32'(alloc_reg[0]), 38);
        check("t3_r1b", 32'(alloc_reg[1]), 39);
        tick();
        check("t3_cnt24", 32'(free_count), 24);
        spec_clear = 1; #1;
        check("t3_clr_gnt", 32'(alloc_gnt), 0);
        check("t3_clr_stall", 32'(stall), 1);
        tick();
        spec_clear = 0; #1;
        check("t3_rec_gnt", 32'(alloc_gnt), 0);
        check("t3_rec_busy", 32'(spec_busy), 1);
        check("t3_rec_cnt", 32'(free_count), 27);
        tick();
        check("t3_run_busy", 32'(spec_busy), 0);
        alloc_req = 2'b01; #1;
        check("t3_re_gnt", 32'(alloc_gnt), 1);
        check("t3_re_r0", 32'(alloc_reg[0]), 37);
        tick();
        check("t3_cnt26b", 32'(free_count), 26);

        // Commit path; clear in RUN is ignored
        alloc_req = 2'b00; spec_begin = 1; spec_slot = 1;
        tick();
        spec_begin = 0;
        check("t4_busy1", 32'(spec_busy), 1);
        spec_commit = 1;
        tick();
        spec_commit = 0;
        check("t4_busy0", 32'(spec_busy), 0);
        spec_clear = 1;
        tick();
        spec_clear = 0;
        check("t4_clr_cnt", 32'(free_count), 26);
        check("t4_clr_busy", 32'(spec_busy), 0);
        check("t4_clr_err", 32'(error), 0);
        alloc_req = 2'b01; #1;
        check("t4_r0", 32'(alloc_reg[0]), 38);
        tick();
        check("t4_cnt25", 32'(free_count), 25);

        // Drain to one entry; a free is not allocatable in its own cycle
        alloc_req = 2'b11;
        repeat (12) tick();
        check("t2_cnt1", 32'(free_count), 1);
        free_valid = 2'b01; free_reg[0] = 6'd40; #1;
        check("t2_short_gnt", 32'(alloc_gnt), 0);
        check("t2_short_stall", 32'(stall), 1);
        tick();
        free_valid = 2'b00;
        check("t2_cnt2", 32'(free_count), 2);
        #1;
        check("t2_gnt", 32'(alloc_gnt), 3);
        check("t2_r0", 32'(alloc_reg[0]), 63);
        check("t2_r1", 32'(alloc_reg[1]), 40);
        tick();
        alloc_req = 2'b00;
        check("t2_cnt0", 32'(free_count), 0);

        // Refill, then 40 alloc/free pairs to wrap head and tail
        for (int i = 0; i < 16; i++) begin
            free_valid = 2'b11;
            free_reg[0] = 6'(32 + 2*i);
            free_reg[1] = 6'(33 + 2*i);
            q.push_back(32 + 2*i);
            q.push_back(33 + 2*i);
            tick();
        end
        free_valid = 2'b00;
        check("t5_full_cnt", 32'(free_count), 32);
        check("t5_full_err", 32'(error), 0);
        alloc_req = 2'b01; #1;
        prev = q.pop_front();
        check("t5_first", 32'(alloc_reg[0]), 32'(prev));
        tick();
        for (int i = 0; i < 40; i++) begin
            free_valid = 2'b01; free_reg[0] = 6'(prev); #1;
            exp_id = q.pop_front();
            check("t5_wrap_id", 32'(alloc_reg[0]), 32'(exp_id));
            q.push_back(prev);
            prev = exp_id;
            tick();
        end
        alloc_req = 2'b00; free_valid = 2'b00;
        check("t5_wrap_cnt", 32'(free_count), 31);
        check("t5_wrap_err", 32'(error), 0);

        // spec_begin while a checkpoint is held
        spec_begin = 1;
        tick();
        tick();
        spec_begin = 0;
        check("t4_dbl_err", 32'(error), 1);
        check("t4_dbl_busy", 32'(spec_busy), 1);

        // Overflow: free while pool is full
        pulse_reset();
        free_valid = 2'b01; free_reg[0] = 6'd50;
        tick();
        free_valid = 2'b00;
        check("t5_ovf_err", 32'(error), 1);
        check("t5_ovf_cnt", 32'(free_count), 32);

        // Illegal free of an architectural id
        pulse_reset();
        alloc_req = 2'b01; free_valid = 2'b01; free_reg[0] = 6'd5; #1;
        check("t5_ill_r0", 32'(alloc_reg[0]), 32);
        tick();
        alloc_req = 2'b00; free_valid = 2'b00;
        check("t5_ill_err", 32'(error), 1);
        check("t5_ill_cnt", 32'(free_count), 31);

        // Reset during SPEC loses the checkpoint
        pulse_reset();
        alloc_req = 2'b11; spec_begin = 1; spec_slot = 0;
        tick();
        spec_begin = 0;
        repeat (10) tick();
        alloc_req = 2'b00;
        check("t6_cnt10", 32'(free_count), 10);
        check("t6_busy", 32'(spec_busy), 1);
        #2;
        rst_n = 1'b0; #1;
        check("t6_rst_cnt", 32'(free_count), 32);
        check("t6_rst_busy", 32'(spec_busy), 0);
        check("t6_rst_err", 32'(error), 0);
        check("t6_rst_gnt", 32'(alloc_gnt), 0);
        rst_n = 1'b1;
        alloc_req = 2'b11; #1;
        check("t6_gnt", 32'(alloc_gnt), 3);
        check("t6_r0", 32'(alloc_reg[0]), 32);
        check("t6_r1", 32'(alloc_reg[1]), 33);
        tick();
        alloc_req = 2'b00;
        check("t6_cnt30", 32'(free_count), 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
